// File: rtl/pdm_pkg.sv
// pdm_pkg: shared state encoding and constants for the PDM pair generator.
// LFSR constants are only consumed when PDM_PAIR_GEN_DITHER_EN is defined.
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } pdm_state_e;

    localparam int PDM_PCM_W   = 16;
    localparam int PDM_MAX_LAG = 255;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_fb(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/sd_mod1.sv
// sd_mod1: first-order sigma-delta modulator, signed PCM in, one bit per step.
// Define PDM_PAIR_GEN_DITHER_EN to add an LFSR carry-in that breaks idle tones.
module sd_mod1
    import pdm_pkg::*;
#(
    parameter int PCM_W = PDM_PCM_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    step,
    input  logic signed [PCM_W-1:0] pcm,
    output logic                    pdm_bit
);

    logic [PCM_W-1:0] acc_q;
    logic [PCM_W-1:0] u;
    logic [PCM_W:0]   sum;
    logic             cin;

    // Two's complement to offset binary: flipping the MSB adds 2^(PCM_W-1)
    assign u = {~pcm[PCM_W-1], pcm[PCM_W-2:0]};

`ifdef PDM_PAIR_GEN_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (clr) begin
            lfsr_q <= LFSR_SEED;
        end else if (step) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb(lfsr_q)};
        end
    end

    assign cin = lfsr_q[0];
`else
    assign cin = 1'b0;
`endif

    assign sum     = {1'b0, acc_q} + {1'b0, u} + {{PCM_W{1'b0}}, cin};
    assign pdm_bit = sum[PCM_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (step) begin
            acc_q <= sum[PCM_W-1:0];
        end
    end

endmodule

// File: rtl/pdm_pair_gen.sv
// pdm_pair_gen: PCM-to-PDM stimulus source driving a lagged data_1/data_2 pair.
// Optional modulator dither is enabled by defining PDM_PAIR_GEN_DITHER_EN.
//
// state | meaning
// IDLE  | en low; outputs 0, hold empty, pcm_ready low
// PRIME | waiting for the first sample to land in the hold
// RUN   | one modulator bit per clock, sample swap every osr_eff bits
module pdm_pair_gen
    import pdm_pkg::*;
#(
    parameter int PCM_W   = PDM_PCM_W,
    parameter int MAX_LAG = PDM_MAX_LAG
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [PCM_W-1:0] pcm_in,
    input  logic                    pcm_valid,
    output logic                    pcm_ready,
    input  logic [7:0]              osr,
    input  logic [7:0]              lag_mag,
    input  logic                    lag_dir,
    output logic                    data_1,
    output logic                    data_2,
    output logic                    pdm_valid,
    output logic                    underrun
);

    localparam int LAG_IW = $clog2(MAX_LAG + 1);

    pdm_state_e state_q, state_d;

    logic signed [PCM_W-1:0] hold_q;
    logic signed [PCM_W-1:0] act_q;
    logic                    hold_full_q;
    logic [7:0]              div_cnt_q;
    logic [7:0]              osr_last;
    logic [MAX_LAG-1:0]      hist_q;
    logic [MAX_LAG:0]        hist_all;
    logic [LAG_IW-1:0]       lag_eff;

    logic prime_entry;
    logic start_run;
    logic run_cyc;
    logic boundary;
    logic move;
    logic xfer;
    logic mod_bit;
    logic lag_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (hold_full_q) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign prime_entry = (state_q == IDLE) && en;
    assign start_run   = (state_q == PRIME) && en && hold_full_q;
    assign run_cyc     = (state_q == RUN) && en;

    assign osr_last = (osr == 8'd0) ? 8'd0 : osr - 8'd1;
    assign boundary = run_cyc && (div_cnt_q == osr_last);
    assign move     = start_run || (boundary && hold_full_q);

    assign pcm_ready = (state_q != IDLE) && !hold_full_q;
    assign xfer      = pcm_valid && pcm_ready;

    // xfer needs an empty hold and move needs a full one, so they never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            act_q       <= '0;
        end else begin
            if (!en) begin
                hold_full_q <= 1'b0;
            end else if (xfer) begin
                hold_full_q <= 1'b1;
            end else if (move) begin
                hold_full_q <= 1'b0;
            end
            if (xfer) begin
                hold_q <= pcm_in;
            end
            if (move) begin
                act_q <= hold_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= 8'd0;
            underrun  <= 1'b0;
        end else begin
            if (prime_entry || start_run) begin
                div_cnt_q <= 8'd0;
            end else if (run_cyc) begin
                div_cnt_q <= boundary ? 8'd0 : div_cnt_q + 8'd1;
            end
            if (prime_entry) begin
                underrun <= 1'b0;
            end else if (boundary && !hold_full_q) begin
                underrun <= 1'b1;
            end
        end
    end

    sd_mod1 #(
        .PCM_W (PCM_W)
    ) u_mod (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (prime_entry),
        .step    (run_cyc),
        .pcm     (act_q),
        .pdm_bit (mod_bit)
    );

    // hist_all[k] is the modulator bit from k cycles ago, k = 0 being this cycle
    assign hist_all = {hist_q, mod_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else if (prime_entry) begin
            hist_q <= '0;
        end else if (run_cyc) begin
            hist_q <= hist_all[MAX_LAG-1:0];
        end
    end

    always_comb begin
        lag_eff = LAG_IW'(MAX_LAG);
        if (int'(lag_mag) < MAX_LAG) begin
            lag_eff = LAG_IW'(lag_mag);
        end
    end

    assign lag_bit = hist_all[lag_eff];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_1    <= 1'b0;
            data_2    <= 1'b0;
            pdm_valid <= 1'b0;
        end else if (run_cyc) begin
            data_1    <= lag_dir ? lag_bit : mod_bit;
            data_2    <= lag_dir ? mod_bit : lag_bit;
            pdm_valid <= 1'b1;
        end else begin
            data_1    <= 1'b0;
            data_2    <= 1'b0;
            pdm_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_pair_gen.sv
// tb_pdm_pair_gen: randomized stimulus against an arithmetic reference model
// of the PDM pair generator (offset PCM accumulation, bit queue for the lag tap).
`timescale 1ns/1ps
module tb_pdm_pair_gen;

    localparam int PCM_W   = 16;
    localparam int MAX_LAG = 255;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [PCM_W-1:0]  pcm_in;
    logic              pcm_valid;
    logic              pcm_ready;
    logic [7:0]        osr;
    logic [7:0]        lag_mag;
    logic              lag_dir;
    logic              data_1;
    logic              data_2;
    logic              pdm_valid;
    logic              underrun;

    always #5 clk = ~clk;

    pdm_pair_gen #(
        .PCM_W   (PCM_W),
        .MAX_LAG (MAX_LAG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pcm_in    (pcm_in),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .osr       (osr),
        .lag_mag   (lag_mag),
        .lag_dir   (lag_dir),
        .data_1    (data_1),
        .data_2    (data_2),
        .pdm_valid (pdm_valid),
        .underrun  (underrun)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // reference model: 0 = idle, 1 = waiting for first sample, 2 = streaming
    int          m_phase;
    bit          m_hold_full;
    logic [15:0] m_hold;
    logic [15:0] m_act;
    int          m_acc;
    int          m_n;
    bit          bitq[$];
    bit          m_under;
    bit          m_d1, m_d2, m_v;

    int          valid_pct;
    bit          fixed_pcm;
    logic [15:0] fixed_val;
    bit          last_xfer;
    int          cyc;

    task automatic model_reset();
        m_phase     = 0;
        m_hold_full = 0;
        m_hold      = '0;
        m_act       = '0;
        m_acc       = 0;
        m_n         = 0;
        bitq.delete();
        m_under     = 0;
        m_d1        = 0;
        m_d2        = 0;
        m_v         = 0;
    endtask

    task automatic model_edge();
        bit ready, xfer, had_sample, b, lb;
        int u, s, lag_eff, osr_eff;
        ready      = (m_phase != 0) && !m_hold_full;
        xfer       = pcm_valid && ready;
        had_sample = m_hold_full;
        m_d1 = 0; m_d2 = 0; m_v = 0;
        if (!en) begin
            m_phase     = 0;
            m_hold_full = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_acc   = 0;
            bitq.delete();
            m_under = 0;
        end else if (m_phase == 1) begin
            if (had_sample) begin
                m_phase     = 2;
                m_act       = m_hold;
                m_hold_full = 0;
                m_n         = 0;
            end
            if (xfer) begin
                m_hold      = pcm_in;
                m_hold_full = 1;
            end
        end else begin
            u     = int'($signed(m_act)) + 32768;
            s     = m_acc + u;
            b     = (s >= 65536);
            m_acc = s % 65536;
            bitq.push_back(b);
            lag_eff = (int'(lag_mag) > MAX_LAG) ? MAX_LAG : int'(lag_mag);
            lb      = (lag_eff <= m_n) ? bitq[m_n - lag_eff] : 1'b0;
            m_d1 = lag_dir ? lb : b;
            m_d2 = lag_dir ? b : lb;
            m_v  = 1;
            osr_eff = (osr == 8'd0) ? 1 : int'(osr);
            if ((m_n % osr_eff) == osr_eff - 1) begin
                if (had_sample) begin
                    m_act       = m_hold;
                    m_hold_full = 0;
                end else begin
                    m_under = 1;
                end
            end
            m_n++;
            if (xfer) begin
                m_hold      = pcm_in;
                m_hold_full = 1;
            end
        end
    endtask

    // called at a negedge; returns at the next negedge with outputs checked
    task automatic tick();
        pcm_valid = ($urandom_range(99) < valid_pct);
        pcm_in    = fixed_pcm ? fixed_val : 16'($urandom);
        #1;
        chk("pcm_ready", pcm_ready, (m_phase != 0) && !m_hold_full);
        last_xfer = pcm_valid && pcm_ready;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("data_1", data_1, m_d1);
        chk("data_2", data_2, m_d2);
        chk("pdm_valid", pdm_valid, m_v);
        chk("underrun", underrun, m_under);
    endtask

    task automatic restart();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data_1"}, data_1, 1'b0);
        chk({tag, "_data_2"}, data_2, 1'b0);
        chk({tag, "_pdm_valid"}, pdm_valid, 1'b0);
        chk({tag, "_underrun"}, underrun, 1'b0);
        chk({tag, "_pcm_ready"}, pcm_ready, 1'b0);
    endtask

    initial begin
        int bits_seen, ur_at, hs_at, pv_at;
        rst_n     = 1'b0;
        en        = 1'b0;
        pcm_in    = '0;
        pcm_valid = 1'b0;
        osr       = 8'd8;
        lag_mag   = 8'd0;
        lag_dir   = 1'b0;
        valid_pct = 100;
        fixed_pcm = 1'b1;
        fixed_val = 16'h0000;
        cyc       = 0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // zero input: alternating 0,1 on both channels, first bit 0
        restart();
        run(60);

        // full-scale positive then full-scale negative
        osr = 8'd64; fixed_val = 16'h7FFF;
        restart();
        run(140);
        fixed_val = 16'h8000;
        restart();
        run(140);

        // quarter-scale stream with a 5-bit lag, both directions
        osr = 8'd8; fixed_val = 16'h4000; lag_mag = 8'd5; lag_dir = 1'b0;
        restart();
        run(80);
        lag_dir = 1'b1;
        run(40);
        lag_dir = 1'b0;
        restart();
        lag_dir = 1'b1;
        run(60);

        // deepest lag with random samples
        fixed_pcm = 1'b0; osr = 8'd3; lag_mag = 8'd255; lag_dir = 1'b0;
        restart();
        run(600);

        // single sample then starve: underrun after 4 bits, sticky until re-prime
        fixed_pcm = 1'b1; fixed_val = 16'h1234; osr = 8'd4; lag_mag = 8'd0;
        restart();
        tick();
        tick();
        valid_pct = 0;
        bits_seen = 0;
        ur_at     = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pdm_valid) bits_seen++;
            if (underrun && ur_at < 0) ur_at = bits_seen;
        end
        chk("underrun_after_bits", ur_at, 4);
        valid_pct = 100;
        run(10);
        restart();
        run(5);

        // osr = 0 behaves as one bit per sample
        fixed_pcm = 1'b0; osr = 8'd0; lag_mag = 8'd3; valid_pct = 100;
        restart();
        run(100);

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            osr       = 8'($urandom_range(0, 12));
            lag_mag   = ($urandom_range(3) == 0) ? 8'($urandom_range(200, 255))
                                                 : 8'($urandom_range(0, 40));
            lag_dir   = 1'($urandom_range(1));
            valid_pct = ($urandom_range(1) == 0) ? 100 : int'($urandom_range(20, 90));
            restart();
            for (int k = 0; k < 8; k++) begin
                run(45);
                if ($urandom_range(2) == 0) lag_mag = 8'($urandom_range(0, 60));
                if ($urandom_range(3) == 0) lag_dir = ~lag_dir;
            end
        end

        // asynchronous reset mid-stream, then restart latency
        fixed_pcm = 1'b1; fixed_val = 16'h2000; osr = 8'd4; lag_mag = 8'd2;
        lag_dir = 1'b0; valid_pct = 100;
        restart();
        run(30);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        hs_at = -1;
        pv_at = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_xfer && hs_at < 0) hs_at = cyc;
            if (pdm_valid && pv_at < 0) pv_at = cyc;
        end
        chk("restart_latency", (hs_at >= 0 && pv_at >= 0) ? pv_at - hs_at : -1, 2);
        run(40);

        // en drop mid-run clears the outputs after one edge
        en = 1'b0;
        tick();
        run(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
